// File: rtl/std_pkg.sv
// Shared definitions for the std serial link (transmitter and receiver).
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package std_pkg;

  // Frame FSM encodings shared by both ends of the link.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

  // Counter width for a modulo-n count; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up-counter with enable; wrap flags the terminal count N-1.
// Latency: count advances one edge after en; wrap is combinational from the count.
// Backpressure: none; holds its value while en is low.
module mod_counter
  import std_pkg::*;
#(
  parameter int N = 8,
  parameter int W = clog2_min1(N)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count;

  assign wrap = (count == LAST);

  // Count 0..N-1 while enabled, returning to 0 after the terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: one WIDTH-bit word out one bit per clock, framed by SVALID/SLAST.
// Latency: first bit on SOUT one cycle after acceptance; back-to-back frames with no gap.
// Backpressure: IN_READY only in IDLE or on the last frame bit; serial side has none. Option: STD_PISO_PARITY_EN.
module piso_serializer
  import std_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             SOUT,
  output logic             SVALID,
  output logic             SLAST,
  output logic             BUSY
);

  localparam int CW = clog2_min1(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic             cnt_wrap;
  logic             in_shift;
  logic             last_data;
  logic             accept;
  logic             sout_bit;

  assign in_shift  = (state_q == ST_SHIFT);
  assign last_data = in_shift & cnt_wrap;
  assign accept    = IN_VALID & IN_READY;
  assign sout_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  // Bit position within the data part of the frame; wraps on the last data bit.
  mod_counter #(
    .N (WIDTH),
    .W (CW)
  ) u_bit_cnt (
    .clk   (CLK),
    .rst_n (RSTn),
    .en    (in_shift),
    .wrap  (cnt_wrap)
  );

  // Frame state register; reset aborts any frame in progress.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a word accepted on the final bit restarts SHIFT without a bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_data) begin
`ifdef STD_PISO_PARITY_EN
          state_d = ST_PAR;
`else
          state_d = accept ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
      ST_PAR: begin
        state_d = accept ? ST_SHIFT : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Capture the word on acceptance, then bring the next bit to the output end each SHIFT cycle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      shreg_q <= '0;
    end else if (accept) begin
      shreg_q <= IN_DATA;
    end else if (in_shift) begin
      shreg_q <= MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
    end
  end

`ifdef STD_PISO_PARITY_EN
  logic par_q;

  // Even parity of the captured word, sent in the trailing PAR cycle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^IN_DATA;
    end
  end

  assign SLAST = (state_q == ST_PAR);
  assign SOUT  = in_shift ? sout_bit : (SLAST & par_q);
`else
  assign SLAST = last_data;
  assign SOUT  = in_shift & sout_bit;
`endif

  // All framing outputs decode from registered state only.
  assign SVALID   = (state_q != ST_IDLE);
  assign BUSY     = SVALID;
  assign IN_READY = (state_q == ST_IDLE) | SLAST;

endmodule
